// File: rtl/sa_cache_pkg.sv
// Shared geometry, per-way line metadata and controller states for the 4-way data cache.
package sa_cache_pkg;
    localparam int CACHE_LINES     = 256;
    localparam int LINE_SIZE_BYTES = 64;
    localparam int WAYS            = 4;
    localparam int TAG_BITS        = 18;
    localparam int INDEX_BITS      = 8;
    localparam int OFFSET_BITS     = 6;
    localparam int DATA_WIDTH      = 32;
    localparam int ADDRESS_WIDTH   = 32;
    localparam int LINE_BITS       = LINE_SIZE_BYTES * 8;
    localparam int WAY_BITS        = $clog2(WAYS);
    localparam int WORD_BITS       = OFFSET_BITS - 2;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic                used;
        logic [TAG_BITS-1:0] tag;
    } line_meta_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;
endpackage

// File: rtl/sa4_cache_core_if.sv
// Core request/response and line-wide memory fill/evict signals of the cache.
interface sa4_cache_core_if;
    import sa_cache_pkg::*;

    logic                     i_req;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic                     memRW;
    logic [DATA_WIDTH-1:0]    dataW;
    logic                     o_ready;
    logic                     o_valid;
    logic [DATA_WIDTH-1:0]    o_data;
    logic                     cache_miss;
    logic [ADDRESS_WIDTH-1:0] o_mem_addr;
    logic                     i_memory_response;
    logic [LINE_BITS-1:0]     i_memory_line;
    logic                     o_evict;
    logic [ADDRESS_WIDTH-1:0] o_evict_addr;
    logic [LINE_BITS-1:0]     o_evict_data;

    modport slave (
        input  i_req, i_addr, memRW, dataW, i_memory_response, i_memory_line,
        output o_ready, o_valid, o_data, cache_miss, o_mem_addr, o_evict, o_evict_addr, o_evict_data
    );

    modport master (
        output i_req, i_addr, memRW, dataW, i_memory_response, i_memory_line,
        input  o_ready, o_valid, o_data, cache_miss, o_mem_addr, o_evict, o_evict_addr, o_evict_data
    );
endinterface

// File: rtl/sa_way_match.sv
// Single-way hit detect: stored tag equals request tag and the line is valid.
// Purely combinational, no backpressure.
module sa_way_match
    import sa_cache_pkg::*;
(
    input  logic                valid,
    input  logic [TAG_BITS-1:0] tag,
    input  logic [TAG_BITS-1:0] req_tag,
    output logic                hit
);
    assign hit = valid & (tag == req_tag);
endmodule

// File: rtl/sa4_cache_core.sv
// 4-way write-back/write-allocate cache, one request in flight; hit completes 2 cycles after acceptance.
// Backpressure: o_ready only in IDLE; misses wait for a single-cycle line fill, dirty victims evict on that edge.
module sa4_cache_core
    import sa_cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    sa4_cache_core_if.slave bus
);
    state_t                state, state_nxt;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_BITS-1:0]  req_word;
    logic                  req_rw;
    logic [DATA_WIDTH-1:0] req_wdata;

    line_meta_t            meta     [WAYS][CACHE_LINES];
    logic [LINE_BITS-1:0]  data_mem [WAYS][CACHE_LINES];

    logic [WAYS-1:0]       hit, set_valid, set_used, new_used;
    logic [WAY_BITS-1:0]   hit_way, victim_q, upd_way, wr_way;
    logic                  any_hit, complete, wr_en;
    logic [LINE_BITS-1:0]  rd_line, wr_line;
    logic [DATA_WIDTH-1:0] resp_word;
    line_meta_t            vic_meta;
    logic                  unused_addr_bits;

    // Prefer an empty way; otherwise the lowest way not recently used.
    function automatic logic [WAY_BITS-1:0] pick_victim(input logic [WAYS-1:0] valid,
                                                        input logic [WAYS-1:0] used);
        logic [WAY_BITS-1:0] v;
        v = '0;
        for (int w = WAYS - 1; w >= 0; w--) if (!used[w])  v = WAY_BITS'(w);
        for (int w = WAYS - 1; w >= 0; w--) if (!valid[w]) v = WAY_BITS'(w);
        return v;
    endfunction

    function automatic logic [WAYS-1:0] lru_update(input logic [WAYS-1:0] used,
                                                   input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:0] onehot, nxt;
        onehot      = '0;
        onehot[way] = 1'b1;
        nxt         = used | onehot;
        if (&nxt) nxt = onehot;
        return nxt;
    endfunction

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign set_valid[g] = meta[g][req_index].valid;
        assign set_used[g]  = meta[g][req_index].used;
        sa_way_match u_match (
            .valid   (meta[g][req_index].valid),
            .tag     (meta[g][req_index].tag),
            .req_tag (req_tag),
            .hit     (hit[g])
        );
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) if (hit[w]) hit_way = WAY_BITS'(w);
    end

    assign any_hit          = |hit;
    assign complete         = (state == LOOKUP && any_hit) || (state == MISS && bus.i_memory_response);
    assign upd_way          = (state == LOOKUP) ? hit_way : victim_q;
    assign new_used         = lru_update(set_used, upd_way);
    assign rd_line          = data_mem[hit_way][req_index];
    assign vic_meta         = meta[victim_q][req_index];
    assign unused_addr_bits = &{1'b0, bus.i_addr[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_req) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = any_hit ? IDLE : MISS;
            MISS:    if (bus.i_memory_response) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line written back on a completing access; its selected word is also the response.
    always_comb begin
        wr_en   = 1'b0;
        wr_way  = hit_way;
        wr_line = rd_line;
        if (state == MISS) begin
            wr_way  = victim_q;
            wr_line = bus.i_memory_line;
            wr_en   = bus.i_memory_response;
        end else if (state == LOOKUP) begin
            wr_en = any_hit & req_rw;
        end
        if (req_rw) wr_line[req_word*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
        resp_word = wr_line[req_word*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bus.o_ready    = (state == IDLE);
    assign bus.cache_miss = (state == MISS);
    assign bus.o_mem_addr = (state == MISS) ? {req_tag, req_index, {OFFSET_BITS{1'b0}}} : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            req_tag          <= '0;
            req_index        <= '0;
            req_word         <= '0;
            req_rw           <= 1'b0;
            req_wdata        <= '0;
            victim_q         <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_data       <= '0;
            bus.o_evict      <= 1'b0;
            bus.o_evict_addr <= '0;
            bus.o_evict_data <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < CACHE_LINES; s++)
                    meta[w][s] <= '0;
        end else begin
            state       <= state_nxt;
            bus.o_valid <= 1'b0;
            bus.o_evict <= 1'b0;
            if (state == IDLE && bus.i_req) begin
                req_tag   <= bus.i_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
                req_index <= bus.i_addr[OFFSET_BITS +: INDEX_BITS];
                req_word  <= bus.i_addr[2 +: WORD_BITS];
                req_rw    <= bus.memRW;
                req_wdata <= bus.dataW;
            end
            if (state == LOOKUP && !any_hit) victim_q <= pick_victim(set_valid, set_used);
            if (complete) begin
                bus.o_valid <= 1'b1;
                bus.o_data  <= resp_word;
                for (int w = 0; w < WAYS; w++) meta[w][req_index].used <= new_used[w];
                if (state == LOOKUP) begin
                    if (req_rw) meta[hit_way][req_index].dirty <= 1'b1;
                end else begin
                    meta[victim_q][req_index] <= '{valid: 1'b1, dirty: req_rw,
                                                   used: new_used[victim_q], tag: req_tag};
                    if (vic_meta.valid && vic_meta.dirty) begin
                        bus.o_evict      <= 1'b1;
                        bus.o_evict_addr <= {vic_meta.tag, req_index, {OFFSET_BITS{1'b0}}};
                        bus.o_evict_data <= data_mem[victim_q][req_index];
                    end
                end
            end
        end
    end

    // Line storage carries no reset; validity lives in meta.
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_way][req_index] <= wr_line;
    end
endmodule

// File: tb/tb_sa4_cache_core.sv
// Table-driven bench for sa4_cache_core with a response scoreboard and reset/spurious-fill sequences.
module tb_sa4_cache_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sa4_cache_core_if bus ();
    sa4_cache_core dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        miss;
        logic [31:0] exp_data;
        logic        evict;
        logic [31:0] ev_addr;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [511:0] ev_line;

    // Fill pattern: byte k = (0x40 + k) XOR (17 * tag[7:0]); tag 0 gives bytes 0x40,0x41,...
    function automatic logic [511:0] fill_line(input logic [31:0] a);
        logic [511:0] ln;
        logic [7:0]   t;
        t = a[21:14] * 8'd17;
        for (int k = 0; k < 64; k++) ln[8*k +: 8] = 8'(k + 64) ^ t;
        return ln;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [511:0] ln;
        ln = fill_line(a);
        return ln[32*a[5:2] +: 32];
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                                input logic miss, input logic [31:0] exp_data,
                                input logic evict, input logic [31:0] ev_addr);
        vec_t v;
        v.addr = addr; v.rw = rw; v.wdata = wdata; v.miss = miss;
        v.exp_data = exp_data; v.evict = evict; v.ev_addr = ev_addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = v.addr; bus.memRW = v.rw; bus.dataW = v.wdata;
        sb_q.push_back(v.exp_data);
        @(negedge clk);
        bus.i_req = 1'b0; bus.i_addr = $urandom; bus.dataW = $urandom;
        check($sformatf("v%0d busy", idx), bus.o_ready, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d miss", idx), bus.cache_miss, v.miss);
        if (v.miss) begin
            check($sformatf("v%0d mem_addr", idx), bus.o_mem_addr, {v.addr[31:6], 6'b0});
            check($sformatf("v%0d no_early_valid", idx), bus.o_valid, 1'b0);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d miss_held", idx), bus.cache_miss, 1'b1);
            bus.i_memory_response = 1'b1;
            bus.i_memory_line     = fill_line(v.addr);
            @(negedge clk);
            bus.i_memory_response = 1'b0;
            bus.i_memory_line     = '0;
            check($sformatf("v%0d miss_clear", idx), bus.cache_miss, 1'b0);
            check($sformatf("v%0d evict", idx), bus.o_evict, v.evict);
            if (v.evict) begin
                check($sformatf("v%0d evict_addr", idx), bus.o_evict_addr, v.ev_addr);
                check($sformatf("v%0d evict_data", idx), bus.o_evict_data, ev_line);
                check($sformatf("v%0d evict_byte8", idx), bus.o_evict_data[64 +: 32], 32'hDEAD_BEEF);
            end
        end
        check($sformatf("v%0d valid", idx), bus.o_valid, 1'b1);
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 1'b1, 1'b0);
        end else begin
            exp = sb_q.pop_front();
            if (bus.o_valid) check($sformatf("v%0d data", idx), bus.o_data, exp);
        end
        @(negedge clk);
        check($sformatf("v%0d valid_pulse", idx), bus.o_valid, 1'b0);
        check($sformatf("v%0d evict_pulse", idx), bus.o_evict, 1'b0);
        check($sformatf("v%0d data_hold", idx), bus.o_data, exp);
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0; bus.memRW = 1'b0; bus.dataW = '0;
        bus.i_memory_response = 1'b0; bus.i_memory_line = '0;

        ev_line = fill_line(32'h0000_1040);
        ev_line[64 +: 32] = 32'hDEAD_BEEF;

        vecs.push_back(mk(32'h0000_1040, 1'b0, 32'h0,         1'b1, 32'h4342_4140, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_1044, 1'b0, 32'h0,         1'b0, 32'h4746_4544, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_1048, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_1048, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_1047, 1'b0, 32'h0,         1'b0, 32'h4746_4544, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_5040, 1'b0, 32'h0,         1'b1, word_of(32'h5040), 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_9040, 1'b0, 32'h0,         1'b1, word_of(32'h9040), 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_D044, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 32'h0));
        // Touch ways 0..2: use bits collapse to way 2 only, so way 0 (dirty 0x1040) is the next victim.
        vecs.push_back(mk(32'h0000_1040, 1'b0, 32'h0,         1'b0, 32'h4342_4140, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_5044, 1'b0, 32'h0,         1'b0, word_of(32'h5044), 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_907C, 1'b0, 32'h0,         1'b0, word_of(32'h907C), 1'b0, 32'h0));
        vecs.push_back(mk(32'h0001_1040, 1'b0, 32'h0,         1'b1, word_of(32'h1_1040), 1'b1, 32'h0000_1040));
        vecs.push_back(mk(32'h0000_5040, 1'b0, 32'h0,         1'b0, word_of(32'h5040), 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_D044, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_1040, 1'b0, 32'h0,         1'b1, 32'h4342_4140, 1'b0, 32'h0));
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h4342_4140, 1'b0, 32'h0));

        repeat (3) @(negedge clk);
        check("rst_ready", bus.o_ready, 1'b1);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_miss", bus.cache_miss, 1'b0);
        check("rst_evict", bus.o_evict, 1'b0);
        check("rst_data", bus.o_data, 32'h0);
        check("rst_mem_addr", bus.o_mem_addr, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Fill response while idle must not disturb any line.
        @(negedge clk);
        bus.i_memory_response = 1'b1;
        bus.i_memory_line     = {512{1'b1}};
        @(negedge clk);
        bus.i_memory_response = 1'b0;
        bus.i_memory_line     = '0;
        check("spurious_valid", bus.o_valid, 1'b0);
        check("spurious_miss", bus.cache_miss, 1'b0);
        check("spurious_ready", bus.o_ready, 1'b1);
        run_vec(mk(32'h0000_5040, 1'b0, 32'h0, 1'b0, word_of(32'h5040), 1'b0, 32'h0), 100);

        // Reset while a miss is outstanding.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_2040; bus.memRW = 1'b0;
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("pre_rst_miss", bus.cache_miss, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", bus.o_ready, 1'b1);
        check("mid_rst_miss", bus.cache_miss, 1'b0);
        check("mid_rst_valid", bus.o_valid, 1'b0);
        check("mid_rst_evict", bus.o_evict, 1'b0);
        check("mid_rst_mem_addr", bus.o_mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus.o_valid, 1'b0);
        run_vec(mk(32'h0000_5040, 1'b0, 32'h0, 1'b1, word_of(32'h5040), 1'b0, 32'h0), 101);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
